// File: rtl/mc_mem_bram_pkg.sv
// Shared memory-interface definitions: command direction encoding and burst length width.
package mc_mem_bram_pkg;

    localparam int MI_LEN_W = 7;

    localparam logic MI_RW_READ  = 1'b1;
    localparam logic MI_RW_WRITE = 1'b0;

endpackage

// File: rtl/mc_mem_bram_ram.sv
// Simple dual-port RAM: one write port and one registered read port, shaped for block-RAM inference.
module mc_mem_bram_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_mem_bram.sv
// Burst memory responder: accepts one read or write burst at a time and streams it to/from a local RAM.
module mc_mem_bram
    import mc_mem_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mi_addr,
    input  logic [MI_LEN_W-1:0]   mi_len,
    input  logic                  mi_rw,
    input  logic                  mi_valid,
    output logic                  mi_ready,
    input  logic [31:0]           mi_wdata,
    output logic                  mi_wack,
    output logic                  mi_wlast,
    output logic [31:0]           mi_rdata,
    output logic                  mi_rstb,
    output logic                  mi_rlast,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a command transfers on any cycle where mi_valid and mi_ready are both high;
    // write data transfers on each cycle mi_wack is high; read data is valid on each cycle mi_rstb is high.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_RDRAIN = 2'd3
    } state_t;

    localparam logic [MEM_AW-1:0]   ADDR_ONE = MEM_AW'(1);
    localparam logic [MI_LEN_W-1:0] CNT_ONE  = MI_LEN_W'(1);

    state_t              state_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [MI_LEN_W-1:0] cnt_q;
    logic                rstb_q;
    logic                rlast_q;

    logic accept;
    logic wr_en;
    logic rd_en;
    logic last_word;

    assign mi_ready  = (state_q == ST_IDLE) && !rst;
    assign accept    = mi_valid && mi_ready;
    // Reset gates the strobes in the same cycle so an aborted write never lands in RAM.
    assign wr_en     = (state_q == ST_WRITE) && !rst;
    assign rd_en     = (state_q == ST_READ) && !rst;
    assign last_word = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            rstb_q  <= 1'b0;
            rlast_q <= 1'b0;
        end else begin
            rstb_q  <= rd_en;
            rlast_q <= rd_en && last_word;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= mi_addr[MEM_AW-1:0];
                        cnt_q   <= mi_len;
                        state_q <= (mi_rw == MI_RW_READ) ? ST_READ : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_q <= addr_q + ADDR_ONE;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (last_word) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    addr_q <= addr_q + ADDR_ONE;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (last_word) begin
                        state_q <= ST_RDRAIN;
                    end
                end
                ST_RDRAIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mi_wack     = wr_en;
    assign mi_wlast    = wr_en && last_word;
    assign mi_rstb     = rstb_q;
    assign mi_rlast    = rlast_q;
    assign dbg_state_o = state_q;

    // Upper address bits alias onto the same RAM words.
    generate
        if (ADDR_WIDTH > MEM_AW) begin : g_alias
            logic unused_upper_addr;
            assign unused_upper_addr = ^mi_addr[ADDR_WIDTH-1:MEM_AW];
        end
    endgenerate

    mc_mem_bram_ram #(
        .AW (MEM_AW),
        .DW (32)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (addr_q),
        .wdata_i (mi_wdata),
        .re_i    (rd_en),
        .raddr_i (addr_q),
        .rdata_o (mi_rdata)
    );

endmodule

// File: tb/tb_mc_mem_bram.sv
// Directed and randomized bursts checked against a flat array model of the memory.
module tb_mc_mem_bram;
    import mc_mem_bram_pkg::*;

    localparam int AW    = 20;
    localparam int MAW   = 10;
    localparam int DEPTH = 1 << MAW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mi_addr;
    logic [6:0]    mi_len;
    logic          mi_rw;
    logic          mi_valid;
    logic          mi_ready;
    logic [31:0]   mi_wdata;
    logic          mi_wack;
    logic          mi_wlast;
    logic [31:0]   mi_rdata;
    logic          mi_rstb;
    logic          mi_rlast;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wbuf [128];

    always #5 clk = ~clk;

    mc_mem_bram #(
        .ADDR_WIDTH (AW),
        .MEM_AW     (MAW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mi_addr     (mi_addr),
        .mi_len      (mi_len),
        .mi_rw       (mi_rw),
        .mi_valid    (mi_valid),
        .mi_ready    (mi_ready),
        .mi_wdata    (mi_wdata),
        .mi_wack     (mi_wack),
        .mi_wlast    (mi_wlast),
        .mi_rdata    (mi_rdata),
        .mi_rstb     (mi_rstb),
        .mi_rlast    (mi_rlast),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [AW-1:0] a, input int i);
        return (int'(a) + i) % DEPTH;
    endfunction

    task automatic issue(input logic [AW-1:0] a, input int len, input logic rw, input logic [31:0] wd0);
        int waited;
        @(negedge clk);
        mi_addr  = a;
        mi_len   = 7'(len);
        mi_rw    = rw;
        mi_valid = 1'b1;
        mi_wdata = wd0;
        waited   = 0;
        while (!mi_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", 32'(mi_ready), 32'd1);
        @(posedge clk);
        #1;
        mi_valid = 1'b0;
        mi_addr  = AW'($urandom);
        mi_len   = 7'($urandom);
        mi_rw    = 1'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int len);
        issue(a, len, MI_RW_WRITE, wbuf[0]);
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            check("wack", 32'(mi_wack), 32'd1);
            check("wlast", 32'(mi_wlast), 32'(i == len));
            check("ready_busy_write", 32'(mi_ready), 32'd0);
            model_mem[widx(a, i)] = wbuf[i];
            @(posedge clk);
            #1;
            if (i < len) mi_wdata = wbuf[i+1];
            else         mi_wdata = $urandom;
        end
        @(negedge clk);
        check("wack_after_burst", 32'(mi_wack), 32'd0);
        check("wlast_after_burst", 32'(mi_wlast), 32'd0);
        check("ready_after_write", 32'(mi_ready), 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int len);
        issue(a, len, MI_RW_READ, 32'd0);
        @(negedge clk);
        check("rstb_latency", 32'(mi_rstb), 32'd0);
        check("ready_busy_issue", 32'(mi_ready), 32'd0);
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            check("rstb", 32'(mi_rstb), 32'd1);
            check("rdata", mi_rdata, model_mem[widx(a, i)]);
            check("rlast", 32'(mi_rlast), 32'(i == len));
            check("ready_busy_read", 32'(mi_ready), 32'd0);
        end
        @(negedge clk);
        check("rstb_after_burst", 32'(mi_rstb), 32'd0);
        check("rlast_after_burst", 32'(mi_rlast), 32'd0);
        check("ready_after_read", 32'(mi_ready), 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            len;
        logic [31:0]   w;

        rst      = 1'b1;
        mi_addr  = '0;
        mi_len   = '0;
        mi_rw    = 1'b0;
        mi_valid = 1'b0;
        mi_wdata = '0;

        // Reset state, with a command offered during reset that must be ignored.
        repeat (3) @(posedge clk);
        #1 mi_valid = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(mi_ready), 32'd0);
        check("rst_wack", 32'(mi_wack), 32'd0);
        check("rst_wlast", 32'(mi_wlast), 32'd0);
        check("rst_rstb", 32'(mi_rstb), 32'd0);
        check("rst_rlast", 32'(mi_rlast), 32'd0);
        mi_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(mi_ready), 32'd1);

        // Fill the whole memory with full-length bursts, using aliased upper address bits.
        for (int blk = 0; blk < DEPTH / 128; blk++) begin
            for (int i = 0; i < 128; i++) wbuf[i] = $urandom;
            a = AW'(blk * 128) | (AW'($urandom_range(0, 1023)) << MAW);
            do_write(a, 127);
        end

        // Single-word write then read.
        wbuf[0] = 32'hcafedead;
        do_write(20'h00010, 0);
        do_read(20'h00010, 0);
        check("cafedead_model", model_mem[16], 32'hcafedead);

        // Sixteen-word burst.
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h1000 + 32'(i);
        do_write(20'h00040, 15);
        do_read(20'h00040, 15);

        // Address wrap at the top of memory.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_write(20'h003fe, 3);
        do_read(20'h00000, 1);
        check("wrap_word3", model_mem[0], 32'd3);
        check("wrap_word4", model_mem[1], 32'd4);
        do_read(20'h003fe, 3);

        // Longest read burst.
        do_read(AW'($urandom), 127);

        // Back-to-back commands with mi_valid held high.
        w = $urandom;
        @(negedge clk);
        mi_addr  = 20'h00200;
        mi_len   = 7'd2;
        mi_rw    = MI_RW_WRITE;
        mi_valid = 1'b1;
        mi_wdata = w;
        check("b2b_ready_idle", 32'(mi_ready), 32'd1);
        @(posedge clk);
        #1;
        mi_rw  = MI_RW_READ;
        mi_len = 7'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_wack", 32'(mi_wack), 32'd1);
            check("b2b_wlast", 32'(mi_wlast), 32'(i == 2));
            check("b2b_ready_busy_write", 32'(mi_ready), 32'd0);
            model_mem[widx(20'h00200, i)] = w;
        end
        @(negedge clk);
        check("b2b_ready_after_wlast", 32'(mi_ready), 32'd1);
        check("b2b_wack_done", 32'(mi_wack), 32'd0);
        @(posedge clk);
        #1 mi_valid = 1'b0;
        @(negedge clk);
        check("b2b_ready_issue", 32'(mi_ready), 32'd0);
        check("b2b_rstb_latency", 32'(mi_rstb), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("b2b_rstb", 32'(mi_rstb), 32'd1);
            check("b2b_rdata", mi_rdata, w);
            check("b2b_rlast", 32'(mi_rlast), 32'(i == 1));
            check("b2b_ready_busy_read", 32'(mi_ready), 32'd0);
        end
        @(negedge clk);
        check("b2b_ready_end", 32'(mi_ready), 32'd1);

        // Reset after five words of a 32-word write.
        for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
        issue(20'h00100, 31, MI_RW_WRITE, wbuf[0]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstw_wack", 32'(mi_wack), 32'd1);
            model_mem[widx(20'h00100, i)] = wbuf[i];
            @(posedge clk);
            #1 mi_wdata = wbuf[i+1];
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstw_no_wack", 32'(mi_wack), 32'd0);
        check("rstw_ready_low", 32'(mi_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_ready_after", 32'(mi_ready), 32'd1);
        check("rstw_wack_after", 32'(mi_wack), 32'd0);
        do_read(20'h00100, 31);

        // Idle cycles with no command: no strobes.
        repeat (3) begin
            @(negedge clk);
            check("idle_wack", 32'(mi_wack), 32'd0);
            check("idle_rstb", 32'(mi_rstb), 32'd0);
        end

        // Randomized bursts.
        for (int n = 0; n < 30; n++) begin
            a   = AW'($urandom);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) begin
                do_read(a, len);
            end else begin
                for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
                do_write(a, len);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
